// File: rtl/xbar_cfg_sequencer.sv
// Crossbar configuration sequencer: steps through a table of select/bypass contexts
// for a programmed number of iterations and drives one-hot crossbar selects.
module xbar_cfg_sequencer #(
  parameter  int NUM_CTX    = 8,
  parameter  int ITER_WIDTH = 16,
  localparam int CW         = $clog2(NUM_CTX),
  localparam int NW         = CW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i__cfg_wr_en,
  input  logic [CW-1:0]         i__cfg_addr,
  input  logic [21:0]           i__cfg_data,
  input  logic                  i__start,
  input  logic [NW-1:0]         i__num_ctx,
  input  logic [ITER_WIDTH-1:0] i__num_iter,
  input  logic                  i__stall,
  input  logic                  i__stop,
  input  logic                  i__err_clr,
  output logic [5:0][5:0]       o__sel,
  output logic [3:0]            o__regbypass,
  output logic [CW-1:0]         o__ctx_idx,
  output logic                  o__running,
  output logic                  o__done,
  output logic                  o__cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                state_q;
  logic [21:0]           ctx_mem_q [NUM_CTX];
  logic [CW-1:0]         ctx_q;
  logic [ITER_WIDTH-1:0] iter_q;
  logic [ITER_WIDTH-1:0] num_iter_q;
  logic [NW-1:0]         num_ctx_q;

  logic                  last_ctx;
  logic                  last_iter;
  logic                  start_ok;
  logic                  finish;
  logic                  load_en;
  logic                  err_set;
  logic [CW-1:0]         ctx_d;
  logic [21:0]           entry_d;

  function automatic logic [5:0][5:0] decode_sel(input logic [17:0] enc);
    logic [5:0][5:0] sel;
    sel = '0;
    for (int i = 0; i < 6; i++) begin
      if (enc[3*i +: 3] < 3'd6) sel[i] = 6'b000001 << enc[3*i +: 3];
    end
    return sel;
  endfunction

  function automatic logic has_illegal(input logic [17:0] enc);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bad = bad | (enc[3*i +: 3] == 3'd6);
    end
    return bad;
  endfunction

  // The context about to be presented is looked up from the next ctx value so
  // that the registered outputs line up with the edge on which ctx changes.
  always_comb begin
    last_ctx  = ({1'b0, ctx_q} == (num_ctx_q - NW'(1)));
    last_iter = (num_iter_q != '0) && (iter_q == (num_iter_q - ITER_WIDTH'(1)));
    start_ok  = i__start && (i__num_ctx != '0) && (i__num_ctx <= NW'(NUM_CTX));
    finish    = i__stop || (!i__stall && last_ctx && last_iter);
    ctx_d     = ((state_q == S_RUN) && !last_ctx) ? ctx_q + CW'(1) : '0;
    entry_d   = ctx_mem_q[ctx_d];
    load_en   = ((state_q == S_IDLE) && start_ok) ||
                ((state_q == S_RUN) && !finish && !i__stall);
    err_set   = ((state_q == S_IDLE) && i__start && !start_ok) ||
                (load_en && has_illegal(entry_d[17:0]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CTX; k++) ctx_mem_q[k] <= 22'h3FFFF;
    end else if (i__cfg_wr_en && (state_q == S_IDLE)) begin
      ctx_mem_q[i__cfg_addr] <= i__cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ctx_q        <= '0;
      iter_q       <= '0;
      num_iter_q   <= '0;
      num_ctx_q    <= '0;
      o__sel       <= '0;
      o__regbypass <= '0;
      o__ctx_idx   <= '0;
      o__running   <= 1'b0;
      o__done      <= 1'b0;
      o__cfg_err   <= 1'b0;
    end else begin
      o__done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q    <= S_RUN;
            num_ctx_q  <= i__num_ctx;
            num_iter_q <= i__num_iter;
            ctx_q      <= '0;
            iter_q     <= '0;
            o__running <= 1'b1;
          end
        end
        S_RUN: begin
          if (finish) begin
            state_q      <= S_DONE;
            o__sel       <= '0;
            o__regbypass <= '0;
            o__ctx_idx   <= '0;
            o__running   <= 1'b0;
            o__done      <= 1'b1;
          end else if (!i__stall) begin
            ctx_q <= ctx_d;
            if (last_ctx && (iter_q != '1)) iter_q <= iter_q + ITER_WIDTH'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (load_en) begin
        o__sel       <= decode_sel(entry_d[17:0]);
        o__regbypass <= entry_d[21:18];
        o__ctx_idx   <= ctx_d;
      end

      // A fresh error outranks a simultaneous clear.
      if (err_set) begin
        o__cfg_err <= 1'b1;
      end else if (i__err_clr) begin
        o__cfg_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xbar_cfg_sequencer.sv
// Directed bench for xbar_cfg_sequencer: per-cycle vector table plus hand-written
// sequences for free-running stop and asynchronous reset.
module tb_xbar_cfg_sequencer;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr = 1'b0;
  logic [2:0]       addr = '0;
  logic [21:0]      data = '0;
  logic             start = 1'b0;
  logic [3:0]       nctx = '0;
  logic [15:0]      niter = '0;
  logic             stall = 1'b0;
  logic             stop = 1'b0;
  logic             clr = 1'b0;
  logic [5:0][5:0]  sel;
  logic [3:0]       rb;
  logic [2:0]       idx;
  logic             run;
  logic             done;
  logic             err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xbar_cfg_sequencer #(.NUM_CTX(8), .ITER_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i__cfg_wr_en (wr),
    .i__cfg_addr  (addr),
    .i__cfg_data  (data),
    .i__start     (start),
    .i__num_ctx   (nctx),
    .i__num_iter  (niter),
    .i__stall     (stall),
    .i__stop      (stop),
    .i__err_clr   (clr),
    .o__sel       (sel),
    .o__regbypass (rb),
    .o__ctx_idx   (idx),
    .o__running   (run),
    .o__done      (done),
    .o__cfg_err   (err)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [21:0] data;
    logic        start;
    logic [3:0]  nctx;
    logic [15:0] niter;
    logic        stall;
    logic        stop;
    logic        clr;
    logic [45:0] exp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [21:0] D0 = 22'h07FFFA;
  localparam logic [21:0] D1 = 22'h027FFF;
  localparam logic [21:0] D2 = 22'h2BBD48;
  localparam logic [35:0] C0 = 36'h000000004;
  localparam logic [35:0] C1 = 36'h400000000;
  localparam logic [35:0] C2 = 36'h008020081;

  function automatic logic [45:0] E(input logic [35:0] s, input logic [3:0] r,
                                    input logic [2:0] i, input logic ru,
                                    input logic d, input logic e);
    return {s, r, i, ru, d, e};
  endfunction

  function automatic vec_t V(input logic w, input logic [2:0] a, input logic [21:0] dd,
                             input logic st, input logic [3:0] nc, input logic [15:0] ni,
                             input logic sl, input logic sp, input logic cl,
                             input logic [45:0] ex);
    vec_t v;
    v.wr = w; v.addr = a; v.data = dd; v.start = st; v.nctx = nc; v.niter = ni;
    v.stall = sl; v.stop = sp; v.clr = cl; v.exp = ex;
    return v;
  endfunction

  function automatic vec_t N(input logic [45:0] ex);
    return V(0, 3'd0, 22'd0, 0, 4'd0, 16'd0, 0, 0, 0, ex);
  endfunction

  task automatic drive(input vec_t v);
    wr = v.wr; addr = v.addr; data = v.data; start = v.start; nctx = v.nctx;
    niter = v.niter; stall = v.stall; stop = v.stop; clr = v.clr;
  endtask

  task automatic idle_inputs();
    drive(N(46'd0));
  endtask

  task automatic check(input string name, input logic [45:0] exp);
    logic [45:0] act;
    act = {sel, rb, idx, run, done, err};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got sel=%h rb=%h idx=%0d run=%b done=%b err=%b, want sel=%h rb=%h idx=%0d run=%b done=%b err=%b",
               name, act[45:10], act[9:6], act[5:3], act[2], act[1], act[0],
               exp[45:10], exp[9:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    // Two-iteration run over ctx0/ctx1
    tbl.push_back(V(1, 3'd0, D0, 0, 4'd0, 16'd0, 0, 0, 0, E(0, 0, 0, 0, 0, 0)));
    tbl.push_back(V(1, 3'd1, D1, 0, 4'd0, 16'd0, 0, 0, 0, E(0, 0, 0, 0, 0, 0)));
    tbl.push_back(V(0, 3'd0, 22'd0, 1, 4'd2, 16'd2, 0, 0, 0, E(C0, 4'h1, 0, 1, 0, 0)));
    tbl.push_back(N(E(C1, 4'h0, 1, 1, 0, 0)));
    tbl.push_back(N(E(C0, 4'h1, 0, 1, 0, 0)));
    tbl.push_back(N(E(C1, 4'h0, 1, 1, 0, 0)));
    tbl.push_back(N(E(0, 0, 0, 0, 1, 0)));
    tbl.push_back(N(E(0, 0, 0, 0, 0, 0)));
    // Three stall cycles, a start ignored in RUN, a write ignored in RUN
    tbl.push_back(V(0, 3'd0, 22'd0, 1, 4'd2, 16'd2, 0, 0, 0, E(C0, 4'h1, 0, 1, 0, 0)));
    tbl.push_back(N(E(C1, 4'h0, 1, 1, 0, 0)));
    tbl.push_back(V(0, 3'd0, 22'd0, 1, 4'd1, 16'd1, 1, 0, 0, E(C1, 4'h0, 1, 1, 0, 0)));
    tbl.push_back(V(0, 3'd0, 22'd0, 0, 4'd0, 16'd0, 1, 0, 0, E(C1, 4'h0, 1, 1, 0, 0)));
    tbl.push_back(V(0, 3'd0, 22'd0, 0, 4'd0, 16'd0, 1, 0, 0, E(C1, 4'h0, 1, 1, 0, 0)));
    tbl.push_back(V(1, 3'd0, 22'd0, 0, 4'd0, 16'd0, 0, 0, 0, E(C0, 4'h1, 0, 1, 0, 0)));
    tbl.push_back(N(E(C1, 4'h0, 1, 1, 0, 0)));
    tbl.push_back(N(E(0, 0, 0, 0, 1, 0)));
    tbl.push_back(N(E(0, 0, 0, 0, 0, 0)));
    // Rejected starts, sticky error, clear, error beats clear
    tbl.push_back(V(0, 3'd0, 22'd0, 1, 4'd0, 16'd1, 0, 0, 0, E(0, 0, 0, 0, 0, 1)));
    tbl.push_back(N(E(0, 0, 0, 0, 0, 1)));
    tbl.push_back(V(0, 3'd0, 22'd0, 0, 4'd0, 16'd0, 0, 0, 1, E(0, 0, 0, 0, 0, 0)));
    tbl.push_back(V(0, 3'd0, 22'd0, 1, 4'd9, 16'd1, 0, 0, 0, E(0, 0, 0, 0, 0, 1)));
    tbl.push_back(V(0, 3'd0, 22'd0, 1, 4'd0, 16'd1, 0, 0, 1, E(0, 0, 0, 0, 0, 1)));
    tbl.push_back(V(0, 3'd0, 22'd0, 0, 4'd0, 16'd0, 0, 0, 1, E(0, 0, 0, 0, 0, 0)));
    // ctx2 carries an illegal code 6 on output 3; ctx0 still holds its old entry
    tbl.push_back(V(1, 3'd2, D2, 0, 4'd0, 16'd0, 0, 0, 0, E(0, 0, 0, 0, 0, 0)));
    tbl.push_back(V(0, 3'd0, 22'd0, 1, 4'd3, 16'd1, 0, 0, 0, E(C0, 4'h1, 0, 1, 0, 0)));
    tbl.push_back(N(E(C1, 4'h0, 1, 1, 0, 0)));
    tbl.push_back(N(E(C2, 4'hA, 2, 1, 0, 1)));
    tbl.push_back(N(E(0, 0, 0, 0, 1, 1)));
    tbl.push_back(N(E(0, 0, 0, 0, 0, 1)));
    tbl.push_back(V(0, 3'd0, 22'd0, 0, 4'd0, 16'd0, 0, 0, 1, E(0, 0, 0, 0, 0, 0)));

    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("reset_state", E(0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Free-running (num_iter=0) for 20 cycles, then stop together with stall
    @(negedge clk);
    drive(V(0, 3'd0, 22'd0, 1, 4'd2, 16'd0, 0, 0, 0, 46'd0));
    @(posedge clk); #1;
    check("free_c0", E(C0, 4'h1, 0, 1, 0, 0));
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      check($sformatf("free_c%0d", c),
            (c % 2) ? E(C1, 4'h0, 1, 1, 0, 0) : E(C0, 4'h1, 0, 1, 0, 0));
    end
    @(negedge clk);
    stop = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    check("stop_done", E(0, 0, 0, 0, 1, 0));
    @(negedge clk);
    idle_inputs();
    start = 1'b1; nctx = 4'd2; niter = 16'd1;
    @(posedge clk); #1;
    check("stop_idle", E(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check("start_in_done_ignored", E(0, 0, 0, 0, 0, 0));

    // Reset dropped mid-run: outputs clear without a clock edge, no done pulse
    @(negedge clk);
    drive(V(0, 3'd0, 22'd0, 1, 4'd2, 16'd3, 0, 0, 0, 46'd0));
    @(posedge clk); #1;
    check("rst_run_c0", E(C0, 4'h1, 0, 1, 0, 0));
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check("rst_run_c1", E(C1, 4'h0, 1, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", E(0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst_hold%0d", c), E(0, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(V(0, 3'd0, 22'd0, 1, 4'd1, 16'd1, 0, 0, 0, 46'd0));
    @(posedge clk); #1;
    check("post_rst_entry_cleared", E(0, 0, 0, 1, 0, 0));
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check("post_rst_done", E(0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    check("post_rst_idle", E(0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
